i2c_burst_ctrl: RTL and testbench

I2C_BURST_CTRL -- requirements
Module: i2c_burst_ctrl

---
 rtl/i2c_burst_ctrl_if.sv | 41 ++++
 rtl/i2c_burst_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_burst_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_burst_ctrl_if.sv
// rtl/i2c_burst_ctrl_if.sv - command, data and I2C master bus bundle for the burst controller
interface i2c_burst_ctrl_if #(
    parameter int ADDR_I2C_SZ = 7,
    parameter int DATA_I2C_SZ = 8,
    parameter int LEN_SZ      = 4
);
    logic                   i_start;
    logic [ADDR_I2C_SZ-1:0] i_slv_addr;
    logic                   i_rw;
    logic [DATA_I2C_SZ-1:0] i_reg_addr;
    logic [LEN_SZ-1:0]      i_len;
    logic [DATA_I2C_SZ-1:0] i_wr_data;
    logic                   i_busy;
    logic                   i_ack_err;
    logic [DATA_I2C_SZ-1:0] i_data_rd_i2c;

    logic                   o_en_i2c;
    logic [ADDR_I2C_SZ-1:0] o_addr_i2c;
    logic                   o_rw;
    logic [DATA_I2C_SZ-1:0] o_data_wr_i2c;
    logic                   o_wr_req;
    logic [DATA_I2C_SZ-1:0] o_rd_data;
    logic                   o_rd_valid;
    logic                   o_busy;
    logic                   o_done;
    logic [1:0]             o_err_code;

    modport slave (
        input  i_start, i_slv_addr, i_rw, i_reg_addr, i_len, i_wr_data,
               i_busy, i_ack_err, i_data_rd_i2c,
        output o_en_i2c, o_addr_i2c, o_rw, o_data_wr_i2c, o_wr_req,
               o_rd_data, o_rd_valid, o_busy, o_done, o_err_code
    );

    modport master (
        output i_start, i_slv_addr, i_rw, i_reg_addr, i_len, i_wr_data,
               i_busy, i_ack_err, i_data_rd_i2c,
        input  o_en_i2c, o_addr_i2c, o_rw, o_data_wr_i2c, o_wr_req,
               o_rd_data, o_rd_valid, o_busy, o_done, o_err_code
    );
endinterface

// File: rtl/i2c_burst_ctrl.sv
// rtl/i2c_burst_ctrl.sv - register-addressed burst read/write sequencer driving a byte-level I2C master
module i2c_burst_ctrl #(
    parameter int ADDR_I2C_SZ = 7,
    parameter int DATA_I2C_SZ = 8,
    parameter int LEN_SZ      = 4,
    parameter int TMO_CYC     = 50_000,
    parameter int TMO_SZ      = 16
) (
    input  logic              clk,
    input  logic              rst,
    i2c_burst_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REG_PH = 3'd1,
        WR_PH  = 3'd2,
        RD_PH  = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam logic [TMO_SZ-1:0] TMO_LAST = TMO_SZ'(TMO_CYC - 1);

    state_e                 state_q;
    logic                   busy_cur_q, busy_prev_q;
    logic                   busy_rise, busy_fall;
    logic [TMO_SZ-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                   tmo_hit;
    logic                   rw_cmd_q;
    logic                   skip_fall_q;
    logic [LEN_SZ-1:0]      remaining_q, rise_cnt_q, fall_cnt_q;
    logic                   en_q, rw_q, wr_req_q, rd_valid_q, busy_q, done_q;
    logic [ADDR_I2C_SZ-1:0] addr_q;
    logic [DATA_I2C_SZ-1:0] data_wr_q, rd_data_q;
    logic [1:0]             err_q;

    function automatic logic [LEN_SZ-1:0] dec_sat(input logic [LEN_SZ-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cur_q  <= 1'b0;
            busy_prev_q <= 1'b0;
        end else begin
            busy_cur_q  <= bus.i_busy;
            busy_prev_q <= busy_cur_q;
        end
    end

    assign busy_rise = busy_cur_q & ~busy_prev_q;
    assign busy_fall = ~busy_cur_q & busy_prev_q;

    // Watchdog on master progress: any busy edge proves the bus is alive.
    always_comb begin
        tmo_hit   = (state_q != IDLE) && (state_q != DONE) && (tmo_cnt_q == TMO_LAST);
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if ((state_q == IDLE) || (state_q == DONE) || busy_rise || busy_fall)
            tmo_cnt_d = '0;
        else if (tmo_hit)
            tmo_cnt_d = tmo_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tmo_cnt_q   <= '0;
            rw_cmd_q    <= 1'b0;
            skip_fall_q <= 1'b0;
            remaining_q <= '0;
            rise_cnt_q  <= '0;
            fall_cnt_q  <= '0;
            en_q        <= 1'b0;
            rw_q        <= 1'b0;
            wr_req_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            data_wr_q   <= '0;
            rd_data_q   <= '0;
            err_q       <= 2'b00;
        end else begin
            wr_req_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            tmo_cnt_q  <= tmo_cnt_d;
            // Timeout outranks NACK and skips STOP since the master is presumed hung.
            if (tmo_hit) begin
                en_q    <= 1'b0;
                err_q   <= 2'b10;
                state_q <= DONE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.i_start) begin
                            rw_cmd_q <= bus.i_rw;
                            if (bus.i_len != '0) begin
                                en_q        <= 1'b1;
                                addr_q      <= bus.i_slv_addr;
                                rw_q        <= 1'b0;
                                data_wr_q   <= bus.i_reg_addr;
                                busy_q      <= 1'b1;
                                err_q       <= 2'b00;
                                remaining_q <= bus.i_len;
                                rise_cnt_q  <= bus.i_len;
                                fall_cnt_q  <= bus.i_len;
                                skip_fall_q <= 1'b1;
                                state_q     <= REG_PH;
                            end else begin
                                err_q   <= 2'b11;
                                state_q <= DONE;
                            end
                        end
                    end
                    REG_PH: begin
                        if (bus.i_ack_err) begin
                            en_q    <= 1'b0;
                            err_q   <= 2'b01;
                            state_q <= STOP;
                        end else if (busy_rise) begin
                            if (rw_cmd_q) begin
                                rw_q    <= 1'b1;
                                state_q <= RD_PH;
                            end else begin
                                wr_req_q  <= 1'b1;
                                data_wr_q <= bus.i_wr_data;
                                state_q   <= WR_PH;
                            end
                        end
                    end
                    WR_PH: begin
                        if (bus.i_ack_err) begin
                            en_q    <= 1'b0;
                            err_q   <= 2'b01;
                            state_q <= STOP;
                        end else if (busy_rise) begin
                            remaining_q <= dec_sat(remaining_q);
                            if (dec_sat(remaining_q) == '0) begin
                                en_q    <= 1'b0;
                                state_q <= STOP;
                            end else begin
                                wr_req_q  <= 1'b1;
                                data_wr_q <= bus.i_wr_data;
                            end
                        end
                    end
                    RD_PH: begin
                        if (bus.i_ack_err) begin
                            en_q    <= 1'b0;
                            err_q   <= 2'b01;
                            state_q <= STOP;
                        end else begin
                            if (busy_rise) begin
                                rise_cnt_q <= dec_sat(rise_cnt_q);
                                if (dec_sat(rise_cnt_q) == '0)
                                    en_q <= 1'b0;
                            end
                            // First fall closes the register-address write, not a data byte.
                            if (busy_fall) begin
                                if (skip_fall_q) begin
                                    skip_fall_q <= 1'b0;
                                end else begin
                                    rd_data_q  <= bus.i_data_rd_i2c;
                                    rd_valid_q <= 1'b1;
                                    fall_cnt_q <= dec_sat(fall_cnt_q);
                                    if (dec_sat(fall_cnt_q) == '0)
                                        state_q <= DONE;
                                end
                            end
                        end
                    end
                    STOP: begin
                        if (bus.i_ack_err)
                            err_q <= 2'b01;
                        if (!busy_cur_q)
                            state_q <= DONE;
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        en_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q     <= IDLE;
                        rw_cmd_q    <= 1'b0;
                        skip_fall_q <= 1'b0;
                        remaining_q <= '0;
                        rise_cnt_q  <= '0;
                        fall_cnt_q  <= '0;
                        en_q        <= 1'b0;
                        rw_q        <= 1'b0;
                        busy_q      <= 1'b0;
                        addr_q      <= '0;
                        data_wr_q   <= '0;
                        rd_data_q   <= '0;
                        err_q       <= 2'b00;
                    end
                endcase
            end
        end
    end

    assign bus.o_en_i2c      = en_q;
    assign bus.o_addr_i2c    = addr_q;
    assign bus.o_rw          = rw_q;
    assign bus.o_data_wr_i2c = data_wr_q;
    assign bus.o_wr_req      = wr_req_q;
    assign bus.o_rd_data     = rd_data_q;
    assign bus.o_rd_valid    = rd_valid_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_err_code    = err_q;
endmodule

// File: tb/tb_i2c_burst_ctrl.sv
// tb/tb_i2c_burst_ctrl.sv - directed bench for i2c_burst_ctrl with a hand-driven I2C master busy line
module tb_i2c_burst_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   wr_cnt;
    int   done_cnt;
    logic [7:0] rd_q[$];
    logic [7:0] rd_exp[6];

    i2c_burst_ctrl_if #(.ADDR_I2C_SZ(7), .DATA_I2C_SZ(8), .LEN_SZ(4)) bus ();

    i2c_burst_ctrl #(
        .ADDR_I2C_SZ(7), .DATA_I2C_SZ(8), .LEN_SZ(4), .TMO_CYC(100), .TMO_SZ(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_wr_req === 1'b1) wr_cnt++;
        if (bus.o_done === 1'b1) done_cnt++;
        if (bus.o_rd_valid === 1'b1) rd_q.push_back(bus.o_rd_data);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [6:0] a, input logic rw, input logic [7:0] r,
                             input logic [3:0] len);
        bus.i_slv_addr = a;
        bus.i_rw       = rw;
        bus.i_reg_addr = r;
        bus.i_len      = len;
        bus.i_start    = 1'b1;
        tick();
        bus.i_start    = 1'b0;
    endtask

    task automatic busy_hi(input int n);
        bus.i_busy = 1'b1;
        repeat (n) tick();
    endtask

    task automatic busy_lo(input int n);
        bus.i_busy = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_write2(input bit poke);
        int w0, d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        start_cmd(7'h68, 1'b0, 8'h6B, 4'd2);
        chk("wr_en_start", bus.o_en_i2c, 1);
        chk("wr_addr", bus.o_addr_i2c, 7'h68);
        chk("wr_rw", bus.o_rw, 0);
        chk("wr_reg_byte", bus.o_data_wr_i2c, 8'h6B);
        chk("wr_busy", bus.o_busy, 1);
        chk("wr_err_start", bus.o_err_code, 2'b00);
        bus.i_wr_data = 8'h00;
        busy_hi(4);
        busy_lo(4);
        chk("wr_req_1", wr_cnt - w0, 1);
        chk("wr_byte0", bus.o_data_wr_i2c, 8'h00);
        bus.i_wr_data = 8'h01;
        if (poke) begin
            bus.i_slv_addr = 7'h11;
            bus.i_len      = 4'd0;
            bus.i_start    = 1'b1;
            tick();
            bus.i_start    = 1'b0;
            chk("ign_start_addr", bus.o_addr_i2c, 7'h68);
            chk("ign_start_err", bus.o_err_code, 2'b00);
            chk("ign_start_en", bus.o_en_i2c, 1);
        end
        busy_hi(4);
        busy_lo(4);
        chk("wr_req_2", wr_cnt - w0, 2);
        chk("wr_byte1", bus.o_data_wr_i2c, 8'h01);
        chk("wr_en_before_last", bus.o_en_i2c, 1);
        bus.i_wr_data = 8'hFF;
        busy_hi(4);
        chk("wr_en_drop", bus.o_en_i2c, 0);
        chk("wr_no_done_yet", done_cnt - d0, 0);
        busy_lo(4);
        chk("wr_done", done_cnt - d0, 1);
        chk("wr_req_total", wr_cnt - w0, 2);
        chk("wr_err_end", bus.o_err_code, 2'b00);
        chk("wr_busy_end", bus.o_busy, 0);
    endtask

    initial begin
        int n, d0, w0;
        logic [7:0] got;
        checks   = 0;
        failures = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        rd_exp   = '{8'h12, 8'h34, 8'hA5, 8'h5A, 8'hFF, 8'h01};
        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_slv_addr = '0; bus.i_rw = 1'b0; bus.i_reg_addr = '0;
        bus.i_len = '0; bus.i_wr_data = '0; bus.i_busy = 1'b0; bus.i_ack_err = 1'b0;
        bus.i_data_rd_i2c = '0;
        repeat (3) tick();
        chk("rst_en", bus.o_en_i2c, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_err", bus.o_err_code, 0);
        chk("rst_addr", bus.o_addr_i2c, 0);
        chk("rst_data_wr", bus.o_data_wr_i2c, 0);
        rst = 1'b0;
        tick();

        // Burst write, len 2, with an ignored second start mid-burst
        do_write2(1'b1);

        // Burst read, len 6
        rd_q.delete();
        d0 = done_cnt;
        start_cmd(7'h68, 1'b1, 8'h3B, 4'd6);
        chk("rd_rw_start", bus.o_rw, 0);
        chk("rd_reg_byte", bus.o_data_wr_i2c, 8'h3B);
        busy_hi(4);
        busy_lo(4);
        chk("rd_rw_toggle", bus.o_rw, 1);
        chk("rd_first_fall_skip", rd_q.size(), 0);
        for (int k = 0; k < 6; k++) begin
            bus.i_data_rd_i2c = rd_exp[k];
            busy_hi(4);
            chk("rd_en_after_rise", bus.o_en_i2c, (k < 5) ? 1 : 0);
            busy_lo(4);
        end
        chk("rd_count", rd_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            got = (i < rd_q.size()) ? rd_q[i] : 8'hxx;
            chk("rd_byte", got, rd_exp[i]);
        end
        chk("rd_done", done_cnt - d0, 1);
        chk("rd_err", bus.o_err_code, 2'b00);

        // Write len 3, NACK on second data byte
        w0 = wr_cnt;
        d0 = done_cnt;
        start_cmd(7'h50, 1'b0, 8'h10, 4'd3);
        bus.i_wr_data = 8'hA1;
        busy_hi(4);
        busy_lo(4);
        bus.i_wr_data = 8'hA2;
        busy_hi(4);
        busy_lo(4);
        bus.i_wr_data = 8'hA3;
        bus.i_ack_err = 1'b1;
        busy_hi(4);
        chk("nack_en_drop", bus.o_en_i2c, 0);
        chk("nack_wait_stop", done_cnt - d0, 0);
        bus.i_ack_err = 1'b0;
        busy_lo(4);
        chk("nack_wr_req", wr_cnt - w0, 2);
        chk("nack_done", done_cnt - d0, 1);
        chk("nack_err", bus.o_err_code, 2'b01);

        // Timeout with the master never going busy
        start_cmd(7'h22, 1'b0, 8'hAA, 4'd1);
        n = 0;
        while (bus.o_done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, 101);
        chk("tmo_err", bus.o_err_code, 2'b10);
        chk("tmo_en", bus.o_en_i2c, 0);
        tick();

        // Zero length
        start_cmd(7'h33, 1'b0, 8'h01, 4'd0);
        chk("zero_en", bus.o_en_i2c, 0);
        chk("zero_err", bus.o_err_code, 2'b11);
        chk("zero_done_early", bus.o_done, 0);
        tick();
        chk("zero_done", bus.o_done, 1);
        chk("zero_en_done", bus.o_en_i2c, 0);
        tick();
        chk("zero_done_pulse", bus.o_done, 0);

        // Reset during read byte 3, then a normal write
        rd_q.delete();
        start_cmd(7'h68, 1'b1, 8'h3B, 4'd6);
        busy_hi(4);
        busy_lo(4);
        for (int k = 0; k < 2; k++) begin
            bus.i_data_rd_i2c = rd_exp[k];
            busy_hi(4);
            busy_lo(4);
        end
        chk("rstmid_bytes", rd_q.size(), 2);
        bus.i_data_rd_i2c = rd_exp[2];
        busy_hi(3);
        chk("rstmid_en_pre", bus.o_en_i2c, 1);
        d0 = done_cnt;
        #3 rst = 1'b1;
        #1;
        chk("rstmid_en", bus.o_en_i2c, 0);
        chk("rstmid_busy", bus.o_busy, 0);
        chk("rstmid_rw", bus.o_rw, 0);
        chk("rstmid_addr", bus.o_addr_i2c, 0);
        bus.i_busy = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rstmid_no_done", done_cnt - d0, 0);
        chk("rstmid_err", bus.o_err_code, 0);
        do_write2(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
